// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - DEFAULT_DATA_WIDTH : default operand / result width
//   - state_t            : controller state encoding
//   - len_width()        : width needed to hold a bit length 0..w
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // A bit length ranges over 0..w inclusive, so one extra bit over clog2(w).
    function automatic int len_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request / result bundle of the divider.
//   start, dividend, divisor              : requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                           : divider -> requester
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int DATA_WIDTH = seq_divider_pkg::DEFAULT_DATA_WIDTH
);

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_msb_length.sv
// -----------------------------------------------------------------------------
// msb_length
// Combinational bit length of an unsigned value: index of the highest set bit
// plus one, or 0 when the value is zero.
//   in     : DATA_WIDTH-bit value
//   length : len_width(DATA_WIDTH)-bit result
// -----------------------------------------------------------------------------
module msb_length
    import seq_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]            in,
    output logic [len_width(DATA_WIDTH)-1:0] length
);

    localparam int LW = len_width(DATA_WIDTH);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        length = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (in[i]) begin
                length = LW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider, one quotient bit per clock.
// Only the significant bits of the dividend are iterated, so an operation
// takes (bit length of dividend) + 2 cycles; zero operands finish in 2.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave
//           start/dividend/divisor in; busy/done/quotient/remainder/
//           div_by_zero out (all outputs registered)
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);

    localparam int LW = len_width(DATA_WIDTH);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] dividend_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [DATA_WIDTH-1:0] shift_q;      // dividend, MSB-aligned, consumed from the top
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [LW-1:0]         cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] quotient_q;
    logic [DATA_WIDTH-1:0] remainder_q;
    logic                  dbz_q;

    logic [LW-1:0]         dividend_len;

    msb_length #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_msb_length (
        .in     (dividend_q),
        .length (dividend_len)
    );

    // One restoring step. The partial remainder is below 2*divisor, so the
    // (DATA_WIDTH+1)-bit difference never overflows and its MSB is the sign.
    logic [DATA_WIDTH:0]   partial_d;
    logic [DATA_WIDTH:0]   diff_d;
    logic                  q_bit_d;
    logic [DATA_WIDTH-1:0] rem_d;
    logic [DATA_WIDTH-1:0] quo_d;

    always_comb begin
        partial_d = {rem_q, shift_q[DATA_WIDTH-1]};
        diff_d    = partial_d - {1'b0, divisor_q};
        q_bit_d   = ~diff_d[DATA_WIDTH];
        rem_d     = q_bit_d ? diff_d[DATA_WIDTH-1:0] : partial_d[DATA_WIDTH-1:0];
        quo_d     = (quo_q << 1) | {{(DATA_WIDTH-1){1'b0}}, q_bit_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            shift_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dividend_q <= bus.dividend;
                        divisor_q  <= bus.divisor;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end

                LOAD: begin
                    cnt_q   <= dividend_len;
                    // Left-align so the first consumed bit is the highest set bit.
                    shift_q <= dividend_q << (LW'(DATA_WIDTH) - dividend_len);
                    rem_q   <= '0;
                    quo_q   <= '0;
                    if (divisor_q == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_q;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (dividend_q == '0) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= ITER;
                    end
                end

                ITER: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: each accepted request pushes its expected
// result and latency; a negedge monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          f;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_if #(.DATA_WIDTH(DW)) bus ();

    seq_divider #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain division, bit length via clog2(a+1).
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.a = a; e.b = b; e.acc = 0;
        if (b == 0) begin
            e.q = '1; e.r = a; e.f = 1'b1; e.lat = 2;
        end else if (a == 0) begin
            e.q = '0; e.r = '0; e.f = 1'b0; e.lat = 2;
        end else begin
            e.q = a / b; e.r = a % b; e.f = 1'b0;
            e.lat = $clog2(int'(a) + 1) + 2;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] q, input logic [DW-1:0] r,
                                input logic f, input int lat);
        exp_t e;
        e.a = '0; e.b = '0; e.q = q; e.r = r; e.f = f; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Monitor: result, flag, latency and single-cycle done.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            check("done_pulse", 32'(prev_done), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("quotient", bus.quotient, mon_e.q);
                check("remainder", bus.remainder, mon_e.r);
                check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.f));
                check("latency", cyc - mon_e.acc + 1, mon_e.lat);
                $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", mon_e.a, mon_e.b,
                         bus.quotient, bus.remainder, bus.div_by_zero, cyc - mon_e.acc + 1);
            end
        end
        prev_done = bus.done;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || bus.busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 1, 0);
    endtask

    // Issue one request at the next idle cycle; optionally expect a result.
    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input exp_t e, input bit push);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        e.a = a; e.b = b; e.acc = cyc;
        if (push) sb_q.push_back(e);
        bus.start    = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = DW'($urandom);
        @(negedge clk);
        check("busy_after_accept", 32'(bus.busy), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [DW-1:0] a, b;
        int mode;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        start_op(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 9), 1'b1);
        start_op(16'hFFFF, 16'd1, mk(16'hFFFF, 16'd0, 1'b0, 18), 1'b1);
        start_op(16'd0, 16'd5, mk(16'd0, 16'd0, 1'b0, 2), 1'b1);
        start_op(16'd5, 16'd0, mk(16'hFFFF, 16'd5, 1'b1, 2), 1'b1);
        wait_drain();
        check("hold_quotient", bus.quotient, 16'hFFFF);
        check("hold_dbz", 32'(bus.div_by_zero), 1);

        // 3/10 with start held high; operands scrambled while busy, then
        // 40000/123 presented for the IDLE cycle right after DONE.
        wait_idle();
        bus.start = 1'b1; bus.dividend = 16'd3; bus.divisor = 16'd10;
        @(posedge clk);
        #1;
        e = mk(16'd0, 16'd3, 1'b0, 4); e.a = 16'd3; e.b = 16'd10; e.acc = cyc;
        sb_q.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            bus.dividend = DW'($urandom);
            bus.divisor  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        bus.dividend = 16'd40000; bus.divisor = 16'd123;
        @(posedge clk);
        #1;
        e = mk(16'd325, 16'd25, 1'b0, 18); e.a = 16'd40000; e.b = 16'd123; e.acc = cyc;
        sb_q.push_back(e);
        bus.start = 1'b0;
        wait_drain();

        // Reset in the middle of 50000/3.
        start_op(16'd50000, 16'd3, mk(16'd0, 16'd0, 1'b0, 0), 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_dbz", 32'(bus.div_by_zero), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        start_op(16'd9, 16'd2, mk(16'd4, 16'd1, 1'b0, 6), 1'b1);
        wait_drain();

        for (int i = 0; i < 1000; i++) begin
            mode = int'($urandom_range(0, 9));
            a = DW'($urandom);
            b = DW'($urandom);
            case (mode)
                0: b = '0;
                1: a = '0;
                2: b = DW'($urandom_range(1, 15));
                3: a = DW'($urandom_range(0, 255));
                default: ;
            endcase
            start_op(a, b, model(a, b), 1'b1);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the operand, quotient and remainder width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, DATA_WIDTH, unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port divisor, input, DATA_WIDTH, unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, single-cycle pulse when results are valid.
REQ-009 SHALL have port quotient, output, DATA_WIDTH, registered result.
REQ-010 SHALL have port remainder, output, DATA_WIDTH, registered result.
REQ-011 SHALL have port div_by_zero, output, 1, flag qualifying the current result; held with it.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ITER and DONE.
REQ-013 IDLE with start=1 SHALL capture both operands and go to LOAD; start=0 stays in IDLE.
REQ-014 LOAD SHALL register Ld, the bit length of dividend (index of the highest set bit + 1, 0 for zero), width clog2(DATA_WIDTH)+1.
REQ-015 LOAD SHALL go to DONE when divisor==0 or dividend==0, and to ITER otherwise, with the iteration counter set to Ld.
REQ-016 ITER SHALL perform one restoring step per cycle, consuming dividend bits Ld-1 down to 0 (MSB first).
REQ-017 Each ITER step SHALL compute the partial remainder as {rem, next bit}.
REQ-018 Each ITER step SHALL subtract divisor using a DATA_WIDTH+1-bit difference, commit the difference when it is non-negative, and shift 1 or 0 into the quotient accordingly.
REQ-019 ITER SHALL decrement the counter each step and go to DONE after exactly Ld steps.
REQ-020 DONE SHALL assert done for exactly one cycle, update quotient, remainder and div_by_zero, and return to IDLE.
REQ-021 Latency SHALL be Ld+2 cycles from the clock edge that accepts start to the cycle in which done is high; the special cases in REQ-015 take 2 cycles.
REQ-022 divisor==0 SHALL yield quotient all-ones, remainder equal to dividend, and div_by_zero=1; this case takes priority over dividend==0.
REQ-023 dividend==0 with a non-zero divisor SHALL yield quotient 0, remainder 0 and div_by_zero=0.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-025 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted, allowing back-to-back operations.
REQ-026 quotient, remainder and div_by_zero SHALL hold their values until the next DONE.
REQ-027 Operand inputs SHALL be don't-care except in the accept cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, regardless of clock.
REQ-029 rst_n low SHALL immediately clear busy, done, quotient, remainder and div_by_zero to 0.
REQ-030 rst_n low SHALL immediately clear the iteration counter and all internal registers to 0.
REQ-031 Reset mid-operation SHALL abort the division with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE/LOAD/ITER/DONE) and the default DATA_WIDTH constant.
REQ-033 The bit-length computation SHALL be a combinational sub-module msb_length (parameter DATA_WIDTH; in -> length, width clog2(DATA_WIDTH)+1), instantiated once.
REQ-034 The implementation SHALL contain no multiplier or divider operators.

Verification
REQ-035 Bench SHALL apply 100/7: q=14, r=2, Ld=7, done 9 cycles after accept.
REQ-036 Bench SHALL apply 16'hFFFF/1: q=16'hFFFF, r=0, done 18 cycles after accept.
REQ-037 Bench SHALL apply 0/5 then 5/0: q=0, r=0, flag 0; then q=16'hFFFF, r=5, flag 1; each done 2 cycles after accept.
REQ-038 Bench SHALL apply 3/10 with start held high throughout: q=0, r=3; further starts ignored until IDLE; a second op 40000/123 is accepted back-to-back, giving q=325, r=25.
REQ-039 Bench SHALL start 50000/3 and assert rst_n low mid-ITER: busy and outputs go to 0 at once with no done; then 9/2 gives q=4, r=1.
REQ-040 Bench SHALL apply a random sweep of 1000 operand pairs with checks against a reference model, and assert that done is never high for two consecutive cycles.
